// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl: reset sequencer between the bench clock source and the DUT.
// It synchronises the release of the raw reset and holds downstream reset low
// for a fixed period. In RUN it provides a run qualifier, a divided
// clock-enable tick and a cycle counter. A soft-reset handshake re-sequences
// the downstream reset without touching the raw reset.
module clk_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int DIV         = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst_req,
    output logic             soft_rst_ack,
    output logic             rst_n_sync,
    output logic             run,
    output logic             tick,
    output logic [CNT_W-1:0] cycle_cnt
);

    // Counters are at least one bit wide so HOLD_CYCLES = 1 and DIV = 1 still elaborate.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_SOFT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_rst_n_sync;
    logic               r_run;
    logic               r_tick;
    logic               r_soft_rst_ack;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic               w_sync_out;

    assign w_sync_out   = r_sync[SYNC_STAGES-1];
    assign rst_n_sync   = r_rst_n_sync;
    assign run          = r_run;
    assign tick         = r_tick;
    assign soft_rst_ack = r_soft_rst_ack;
    assign cycle_cnt    = r_cycle_cnt;

    // Reset synchroniser: clears at once on rst_n, then fills with ones one edge at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencing FSM: RESET -> HOLD -> RUN, with RUN -> SOFT -> HOLD on soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RESET;
            r_hold_cnt     <= '0;
            r_div_cnt      <= '0;
            r_rst_n_sync   <= 1'b0;
            r_run          <= 1'b0;
            r_tick         <= 1'b0;
            r_soft_rst_ack <= 1'b0;
            r_cycle_cnt    <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (w_sync_out) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= ST_RUN;
                        r_rst_n_sync <= 1'b1;
                        r_run        <= 1'b1;
                        r_div_cnt    <= '0;
                        r_cycle_cnt  <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Soft reset wins over the tick/count update on the same edge.
                    if (soft_rst_req) begin
                        r_state        <= ST_SOFT;
                        r_rst_n_sync   <= 1'b0;
                        r_run          <= 1'b0;
                        r_tick         <= 1'b0;
                        r_div_cnt      <= '0;
                        r_cycle_cnt    <= '0;
                        r_soft_rst_ack <= 1'b1;
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                        if (r_div_cnt == DIV_LAST) begin
                            r_div_cnt <= '0;
                            r_tick    <= 1'b1;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                            r_tick    <= 1'b0;
                        end
                    end
                end
                ST_SOFT: begin
                    r_state        <= ST_HOLD;
                    r_hold_cnt     <= '0;
                    r_soft_rst_ack <= 1'b0;
                end
                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed testbench for clk_rst_ctrl: a default-parameter instance plus a
// CNT_W=4 / DIV=1 instance, both on the same clock.
module tb_clk_rst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        ack;
    logic        rsync;
    logic        run;
    logic        tick;
    logic [31:0] cnt;

    logic        rst_n2;
    logic        req2;
    logic        ack2;
    logic        rsync2;
    logic        run2;
    logic        tick2;
    logic [3:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_rst_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (req),
        .soft_rst_ack (ack),
        .rst_n_sync   (rsync),
        .run          (run),
        .tick         (tick),
        .cycle_cnt    (cnt)
    );

    clk_rst_ctrl #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (16),
        .DIV         (1),
        .CNT_W       (4)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n2),
        .soft_rst_req (req2),
        .soft_rst_ack (ack2),
        .rst_n_sync   (rsync2),
        .run          (run2),
        .tick         (tick2),
        .cycle_cnt    (cnt2)
    );

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        step(3);
        checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL reset_rsync: got %b expected 0", rsync); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", run); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        rst_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1);
            checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL seq_rsync_low E%0d: got %b expected 0", i, rsync); end
            checks++; if (run !== 1'b0) begin errors++; $display("FAIL seq_run_low E%0d: got %b expected 0", i, run); end
        end
        step(1);
        checks++; if (rsync !== 1'b1) begin errors++; $display("FAIL seq_rsync_E19: got %b expected 1", rsync); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL seq_run_E19: got %b expected 1", run); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL seq_cnt_E19: got %0d expected 0", cnt); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL seq_tick_E19: got %b expected 0", tick); end
    endtask

    task automatic test_first_tick();
        for (int k = 1; k <= 4; k++) begin
            step(1);
            checks++; if (tick !== (k == 4)) begin errors++; $display("FAIL first_tick E%0d: got %b expected %b", 19 + k, tick, (k == 4)); end
            checks++; if (cnt !== k) begin errors++; $display("FAIL first_cnt E%0d: got %0d expected %0d", 19 + k, cnt, k); end
        end
        step(1);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL first_tick_E24: got %b expected 0", tick); end
        checks++; if (cnt !== 32'd5) begin errors++; $display("FAIL first_cnt_E24: got %0d expected 5", cnt); end
    endtask

    task automatic test_soft_pulse();
        step(45);
        checks++; if (cnt !== 32'd50) begin errors++; $display("FAIL soft_pre_cnt: got %0d expected 50", cnt); end
        req = 1'b1;
        step(1);
        req = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL soft_ack: got %b expected 1", ack); end
        checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL soft_rsync: got %b expected 0", rsync); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL soft_run: got %b expected 0", run); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL soft_cnt: got %0d expected 0", cnt); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL soft_tick: got %b expected 0", tick); end
        step(1);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL soft_ack_width: got %b expected 0", ack); end
        checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL soft_rsync_S1: got %b expected 0", rsync); end
        for (int i = 2; i <= 16; i++) begin
            step(1);
            checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL soft_hold_rsync S+%0d: got %b expected 0", i, rsync); end
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL soft_hold_ack S+%0d: got %b expected 0", i, ack); end
        end
        step(1);
        checks++; if (rsync !== 1'b1) begin errors++; $display("FAIL soft_rsync_S17: got %b expected 1", rsync); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL soft_run_S17: got %b expected 1", run); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL soft_cnt_S17: got %0d expected 0", cnt); end
    endtask

    task automatic test_steady();
        int ticks_seen;
        ticks_seen = 0;
        for (int k = 1; k <= 400; k++) begin
            step(1);
            if (tick === 1'b1) ticks_seen++;
            checks++; if (cnt !== k) begin errors++; $display("FAIL steady_cnt k=%0d: got %0d expected %0d", k, cnt, k); end
            checks++; if (tick !== ((k % 4) == 0)) begin errors++; $display("FAIL steady_tick k=%0d: got %b expected %b", k, tick, ((k % 4) == 0)); end
        end
        checks++; if (ticks_seen != 100) begin errors++; $display("FAIL steady_tick_count: got %0d expected 100", ticks_seen); end
    endtask

    task automatic test_async_reset();
        // Mid-RUN: reset between edges, outputs must clear with no clock edge.
        rst_n = 1'b0;
        #1;
        checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL async_run_rsync: got %b expected 0", rsync); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL async_run_run: got %b expected 0", run); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_run_tick: got %b expected 0", tick); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL async_run_ack: got %b expected 0", ack); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL async_run_cnt: got %0d expected 0", cnt); end
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1);
            checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL async_run_restart E%0d: got %b expected 0", i, rsync); end
        end
        step(1);
        checks++; if (rsync !== 1'b1) begin errors++; $display("FAIL async_run_restart_E19: got %b expected 1", rsync); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL async_run_restart_run: got %b expected 1", run); end

        // Mid-HOLD at hold_cnt = 8 (edge E11 after a fresh release).
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step(11);
        rst_n = 1'b0;
        #1;
        checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL async_hold_rsync: got %b expected 0", rsync); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL async_hold_run: got %b expected 0", run); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_hold_tick: got %b expected 0", tick); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL async_hold_cnt: got %0d expected 0", cnt); end
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1);
            checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL async_hold_restart E%0d: got %b expected 0", i, rsync); end
        end
        step(1);
        checks++; if (rsync !== 1'b1) begin errors++; $display("FAIL async_hold_restart_E19: got %b expected 1", rsync); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL async_hold_restart_run: got %b expected 1", run); end
    endtask

    task automatic test_held_req();
        // Entered with the DUT just in RUN; ack every 18 edges, RUN for one cycle.
        req = 1'b1;
        for (int j = 1; j <= 54; j++) begin
            step(1);
            checks++; if (ack !== ((j % 18) == 1)) begin errors++; $display("FAIL held_ack j=%0d: got %b expected %b", j, ack, ((j % 18) == 1)); end
            checks++; if (run !== ((j % 18) == 0)) begin errors++; $display("FAIL held_run j=%0d: got %b expected %b", j, run, ((j % 18) == 0)); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL held_tick j=%0d: got %b expected 0", j, tick); end
        end
        req = 1'b0;
    endtask

    task automatic test_div1_wrap();
        rst_n2 = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            req2 = (i >= 5 && i <= 12);
            step(1);
            checks++; if (rsync2 !== 1'b0) begin errors++; $display("FAIL div1_rsync_low E%0d: got %b expected 0", i, rsync2); end
            checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL div1_hold_ack E%0d: got %b expected 0", i, ack2); end
        end
        req2 = 1'b0;
        step(1);
        checks++; if (rsync2 !== 1'b1) begin errors++; $display("FAIL div1_rsync_E19: got %b expected 1", rsync2); end
        checks++; if (run2 !== 1'b1) begin errors++; $display("FAIL div1_run_E19: got %b expected 1", run2); end
        checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL div1_cnt_E19: got %0d expected 0", cnt2); end
        checks++; if (tick2 !== 1'b0) begin errors++; $display("FAIL div1_tick_E19: got %b expected 0", tick2); end
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++; if (tick2 !== 1'b1) begin errors++; $display("FAIL div1_tick k=%0d: got %b expected 1", k, tick2); end
            checks++; if (cnt2 !== (k % 16)) begin errors++; $display("FAIL div1_cnt k=%0d: got %0d expected %0d", k, cnt2, (k % 16)); end
            checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL div1_ack k=%0d: got %b expected 0", k, ack2); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        req    = 1'b0;
        rst_n2 = 1'b0;
        req2   = 1'b0;
        test_reset();
        test_first_tick();
        test_soft_pulse();
        test_steady();
        test_async_reset();
        test_held_req();
        test_div1_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_rst_ctrl.md
Name: clk_rst_ctrl

Overview:
Clock/reset sequencing stage that sits between the bench clock source and the design under test.
- Takes the single bench clock and the raw asynchronous active-low reset.
- Produces a reset for downstream logic that asserts asynchronously and deasserts synchronously after a hold-off period.
- Also produces a "run" qualifier, a divided clock-enable tick and a free-running cycle counter.
- Supports a soft-reset request/acknowledge handshake that re-sequences downstream reset without touching the raw reset.

Parameters:
SYNC_STAGES, 2, depth of the reset synchroniser flop chain; legal values are 2 or more.
HOLD_CYCLES, 16, number of clk cycles spent in HOLD before RUN; legal values are 1 or more.
DIV, 4, tick period in clk cycles; legal values are 1 or more.
CNT_W, 32, width of cycle_cnt.

Ports:
clk  input  1  the single clock; all logic is on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
soft_rst_req  input  1  soft-reset request; a level sampled on clk.
soft_rst_ack  output  1  one-cycle pulse acknowledging an accepted soft reset.
rst_n_sync  output  1  downstream reset, active-low; registered.
run  output  1  high while in RUN; registered.
tick  output  1  clock-enable pulse, high once every DIV cycles in RUN; registered.
cycle_cnt  output  CNT_W  number of RUN cycles since last entry to RUN.

Behaviour:
Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Reset (rst_n low), taking effect immediately and independent of clk:
- sync chain = 0, state = RESET, hold_cnt = 0, div_cnt = 0.
- Outputs: rst_n_sync = 0, run = 0, tick = 0, soft_rst_ack = 0, cycle_cnt = 0.
- Applies at any time, including mid-HOLD or mid-RUN; every output drops in the same delta with no clk edge required.

Synchroniser:
- The chain shifts in 1 per clk edge after rst_n rises.
- Its output is high after SYNC_STAGES edges.

State machine (states RESET, HOLD, RUN, SOFT):
- RESET: the first edge with the synchroniser output high moves to HOLD with hold_cnt = 0.
- HOLD: hold_cnt increments each edge. At the edge where hold_cnt == HOLD_CYCLES-1:
  - move to RUN;
  - rst_n_sync <= 1, run <= 1, div_cnt <= 0, cycle_cnt <= 0.
- RUN, on each edge:
  - cycle_cnt increments and wraps from all-ones to 0.
  - If div_cnt == DIV-1: div_cnt <= 0 and tick <= 1. Otherwise div_cnt increments and tick <= 0.
  - With DIV = 1, tick is constantly 1 from the second RUN cycle onward.
- RUN with soft_rst_req = 1 at an edge: that edge moves to SOFT. Soft reset takes priority over the tick/count update on that edge.
  - rst_n_sync <= 0, run <= 0, tick <= 0, div_cnt <= 0, cycle_cnt <= 0.
  - soft_rst_ack <= 1.
- SOFT: the next edge unconditionally moves to HOLD, with hold_cnt <= 0 and soft_rst_ack <= 0. soft_rst_ack is therefore exactly one cycle wide.
- soft_rst_req is ignored in RESET, HOLD and SOFT.
- If soft_rst_req is held high, every entry to RUN is followed by SOFT one edge later. RUN then lasts exactly one cycle per sequence and this is legal.

Timing:
- Taking rst_n rising between edges, and E1 as the first edge after it:
  - HOLD is entered at edge E(SYNC_STAGES+1).
  - RUN is entered, and rst_n_sync rises, at edge E(SYNC_STAGES+1+HOLD_CYCLES).
- After a soft reset, rst_n_sync is low for HOLD_CYCLES+1 cycles.
- Outputs are glitch-free: all are flop outputs; rst_n_sync falls asynchronously only through rst_n.

Test Plan:
- Defaults; rst_n released before E1 -> rst_n_sync and run rise at E19; tick is first high after E23 (one cycle); cycle_cnt = 4 after E23.
- Defaults, steady RUN -> tick high exactly 1 cycle in every 4; 100 consecutive ticks spaced 4 apart; cycle_cnt strictly +1 per edge.
- soft_rst_req pulsed for one cycle with cycle_cnt = 50 -> next edge gives soft_rst_ack = 1 for one cycle and rst_n_sync = 0, run = 0, cycle_cnt = 0; rst_n_sync rises again 17 edges after the SOFT entry.
- rst_n driven low mid-HOLD (hold_cnt = 8) and mid-RUN -> all outputs 0 immediately with no clk edge; on release the full 19-edge sequence restarts.
- CNT_W = 4, DIV = 1 -> tick constantly 1 from the second RUN cycle; cycle_cnt counts 0..15 then wraps to 0; soft_rst_req asserted in HOLD is ignored (no ack).
- soft_rst_req held high permanently -> repeating pattern of RUN 1 cycle, SOFT 1 cycle, HOLD 16 cycles; soft_rst_ack period 18 cycles; tick never asserts with DIV = 4.
